// File: rtl/timer_arb_pkg.sv
// Shared types and defaults for the round-robin timer arbiter.
package timer_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } tarb_state_e;

    localparam int CNT_W_DEFAULT   = 26;
    localparam int NUM_REQ_DEFAULT = 4;

    // Successor of idx in a ring of n slots.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/timer_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr, wrapping upward.
module rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic                       any_valid,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic [NUM_REQ-1:0]         onehot
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int scan_idx;

    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        onehot    = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // rr_ptr is always < NUM_REQ, so a single subtraction wraps the scan.
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!any_valid && req[scan_idx]) begin
                any_valid        = 1'b1;
                winner           = IDX_W'(scan_idx);
                onehot[scan_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// One shared one-shot countdown timer granted round-robin among NUM_REQ requesters.
module timer_arbiter
    import timer_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic                       clk50,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*CNT_W-1:0]   delay,
    input  logic                       abort,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic                       aborted,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] active_id
);

    localparam int IDX_W = $clog2(NUM_REQ);

    tarb_state_e        state, state_nxt;
    logic [CNT_W-1:0]   counter, counter_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [NUM_REQ-1:0] grant_nxt, done_nxt;
    logic               aborted_nxt, busy_nxt;
    logic [IDX_W-1:0]   active_id_nxt;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [CNT_W-1:0]   pick_delay;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .any_valid (pick_valid),
        .winner    (pick_idx),
        .onehot    (pick_onehot)
    );

    assign pick_delay = delay[pick_idx*CNT_W +: CNT_W];

    always_ff @(posedge clk50) begin
        if (!rst) begin
            state     <= IDLE;
            counter   <= '0;
            rr_ptr    <= '0;
            grant     <= '0;
            done      <= '0;
            aborted   <= 1'b0;
            busy      <= 1'b0;
            active_id <= '0;
        end else begin
            state     <= state_nxt;
            counter   <= counter_nxt;
            rr_ptr    <= rr_ptr_nxt;
            grant     <= grant_nxt;
            done      <= done_nxt;
            aborted   <= aborted_nxt;
            busy      <= busy_nxt;
            active_id <= active_id_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        counter_nxt   = counter;
        rr_ptr_nxt    = rr_ptr;
        grant_nxt     = '0;
        done_nxt      = '0;
        aborted_nxt   = 1'b0;
        busy_nxt      = busy;
        active_id_nxt = active_id;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_nxt     = pick_onehot;
                    // A zero delay is treated as one cycle so the counter never starts at 0.
                    counter_nxt   = (pick_delay == '0) ? CNT_W'(1) : pick_delay;
                    active_id_nxt = pick_idx;
                    busy_nxt      = 1'b1;
                    rr_ptr_nxt    = IDX_W'(wrap_inc(int'(pick_idx), NUM_REQ));
                    state_nxt     = COUNT;
                end
            end
            COUNT: begin
                // Abort outranks expiry on the same edge.
                if (abort) begin
                    aborted_nxt = 1'b1;
                    busy_nxt    = 1'b0;
                    state_nxt   = IDLE;
                end else if (counter == CNT_W'(1)) begin
                    done_nxt  = NUM_REQ'(1) << active_id;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    counter_nxt = counter - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: time-based reference model checked every cycle plus directed scenarios.
module tb_timer_arbiter;

    localparam int N  = 4;
    localparam int CW = 26;

    logic           clk50 = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*CW-1:0] delay;
    logic           abort;
    logic [N-1:0]   grant, done;
    logic           aborted, busy;
    logic [1:0]     active_id;

    int checks   = 0;
    int failures = 0;

    always #10 clk50 = ~clk50;

    timer_arbiter #(
        .NUM_REQ (N),
        .CNT_W   (CW)
    ) dut (
        .clk50     (clk50),
        .rst       (rst),
        .req       (req),
        .delay     (delay),
        .abort     (abort),
        .grant     (grant),
        .done      (done),
        .aborted   (aborted),
        .busy      (busy),
        .active_id (active_id)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: got no event expected one within bound at t=%0t", nm, $time);
    endtask

    // Reference model: ownership is tracked as an absolute expiry cycle rather than a counter.
    int         cyc = 0;
    bit         model_on = 0;
    bit         m_busy = 0;
    int         m_owner = 0;
    int         m_end = 0;
    int         m_rr = 0;
    int         w, d;
    logic [N-1:0] e_grant = '0, e_done = '0;
    logic       e_aborted = 1'b0, e_busy = 1'b0;
    logic [1:0] e_id = '0;

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk50) begin
        cyc++;
        model_on  = 1;
        e_grant   = '0;
        e_done    = '0;
        e_aborted = 1'b0;
        if (!rst) begin
            m_busy = 0;
            m_rr   = 0;
            e_id   = '0;
        end else if (!m_busy) begin
            w = rr_pick(req, m_rr);
            if (w >= 0) begin
                d = int'(delay[w*CW +: CW]);
                if (d == 0) d = 1;
                m_end      = cyc + d;
                m_owner    = w;
                m_busy     = 1;
                m_rr       = (w + 1) % N;
                e_grant[w] = 1'b1;
                e_id       = 2'(w);
            end
        end else begin
            if (abort) begin
                e_aborted = 1'b1;
                m_busy    = 0;
            end else if (cyc == m_end) begin
                e_done[m_owner] = 1'b1;
                m_busy          = 0;
            end
        end
        e_busy = m_busy;
    end

    always @(negedge clk50) begin
        if (model_on) begin
            cmp("grant", 32'(grant), 32'(e_grant));
            cmp("done", 32'(done), 32'(e_done));
            cmp("aborted", 32'(aborted), 32'(e_aborted));
            cmp("busy", 32'(busy), 32'(e_busy));
            cmp("active_id", 32'(active_id), 32'(e_id));
        end
    end

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    task automatic set_delay(input int ch, input int v);
        delay[ch*CW +: CW] = CW'(v);
    endtask

    task automatic wait_grant(output int idx, output int n);
        idx = -1;
        n   = 0;
        repeat (50) begin
            tick();
            n++;
            if (grant != '0) begin
                for (int k = 0; k < N; k++) if (grant[k]) idx = k;
                return;
            end
        end
        timeout_fail("wait_grant");
    endtask

    task automatic wait_end(output logic [N-1:0] dn, output logic ab, output int lat, output int bc);
        lat = 0;
        bc  = busy ? 1 : 0;
        dn  = '0;
        ab  = 1'b0;
        repeat (100) begin
            tick();
            lat++;
            if (done != '0 || aborted) begin
                dn = done;
                ab = aborted;
                return;
            end
            if (busy) bc++;
        end
        timeout_fail("wait_end");
    endtask

    int         idx, n, lat, bc;
    logic [N-1:0] dn;
    logic       ab;

    initial begin
        rst   = 1'b0;
        req   = 4'b1111;
        abort = 1'b0;
        delay = '0;
        for (int ch = 0; ch < N; ch++) set_delay(ch, 2);

        // Reset held with all requests asserted
        repeat (3) tick();
        cmp("rst_grant", 32'(grant), 32'h0);
        cmp("rst_done", 32'(done), 32'h0);
        cmp("rst_aborted", 32'(aborted), 32'h0);
        cmp("rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        wait_grant(idx, n);
        cmp("rst_first_ch", idx, 0);
        cmp("rst_first_vec", 32'(grant), 32'h1);
        req = '0;
        wait_end(dn, ab, lat, bc);
        cmp("rst_first_done", 32'(dn), 32'h1);

        // Single request, delay 5
        set_delay(1, 5);
        req = 4'b0010;
        wait_grant(idx, n);
        cmp("single_grant", 32'(grant), 32'h2);
        req = '0;
        wait_end(dn, ab, lat, bc);
        cmp("single_done", 32'(dn), 32'h2);
        cmp("single_latency", lat, 5);
        cmp("single_busy_cycles", bc, 5);

        // Fairness from a fresh pointer
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req = 4'b1111;
        for (int ch = 0; ch < N; ch++) set_delay(ch, 2);
        for (int k = 0; k < 5; k++) begin
            wait_grant(idx, n);
            cmp("fair_order", idx, k % 4);
            cmp("fair_gap", n, 1);
            wait_end(dn, ab, lat, bc);
            cmp("fair_latency", lat, 2);
            cmp("fair_done", 32'(dn), 32'(1) << (k % 4));
        end
        req = '0;

        // Zero delay behaves as one cycle
        set_delay(2, 0);
        req = 4'b0100;
        wait_grant(idx, n);
        cmp("zero_grant_ch", idx, 2);
        req = '0;
        wait_end(dn, ab, lat, bc);
        cmp("zero_latency", lat, 1);
        cmp("zero_done", 32'(dn), 32'h4);

        // Abort mid-countdown
        set_delay(3, 10);
        req = 4'b1000;
        wait_grant(idx, n);
        req = '0;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        cmp("abort_mid_aborted", 32'(aborted), 32'h1);
        cmp("abort_mid_done", 32'(done), 32'h0);
        cmp("abort_mid_busy", 32'(busy), 32'h0);
        repeat (12) tick();

        // Abort on the expiry edge
        set_delay(3, 3);
        req = 4'b1000;
        wait_grant(idx, n);
        req = '0;
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        cmp("abort_exp_aborted", 32'(aborted), 32'h1);
        cmp("abort_exp_done", 32'(done), 32'h0);
        repeat (4) tick();

        // Reset while counting with counter at 7
        set_delay(2, 20);
        req = 4'b0100;
        wait_grant(idx, n);
        req = '0;
        repeat (13) tick();
        rst = 1'b0;
        tick();
        cmp("midrst_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        req = 4'b1001;
        wait_grant(idx, n);
        cmp("midrst_next_ch", idx, 0);
        req = '0;
        wait_end(dn, ab, lat, bc);
        repeat (25) tick();

        // Randomized traffic against the model
        repeat (3000) begin
            req   = N'($urandom);
            for (int ch = 0; ch < N; ch++) set_delay(ch, $urandom_range(0, 8));
            abort = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst   = 1'b1;
        abort = 1'b0;
        req   = '0;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
